sbox_lane_engine: RTL

- Parametrised, multi-lane AES byte-substitution engine for the datapath of the AES-128 encrypt/decrypt cores.
- Accepts one WORD_BYTES-wide state word per transaction and substitutes every byte through LANES S-box instances, LANES bytes per cycle.
- Mode is selected per transaction: inverse (decrypt) or, when compiled in, forward (encrypt).
- Valid/ready handshakes on both sides, so it can sit between round-key and shift-rows stages under backpressure.

---
 rtl/sbox_lane_engine.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sbox_lane_engine.sv
// Multi-lane AES byte-substitution engine: one word per transaction, LANES bytes per cycle.
// Build option: define SBOX_LANE_FWD_EN to add the forward S-box and make in_inverse select the direction.
module sbox_lane_engine #(
  parameter int WORD_BYTES = 16,
  parameter int LANES      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*WORD_BYTES-1:0] in_word,
  input  logic                    in_inverse,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_word,
  output logic                    busy
);

  localparam int BEATS = WORD_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Entry 0 sits in the top byte; entry b is selected at bit offset 8*(255-b).
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_TABLE[{~b, 3'b000} +: 8];
  endfunction

`ifdef SBOX_LANE_FWD_EN
  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return FWD_TABLE[{~b, 3'b000} +: 8];
  endfunction

  logic mode_reg, mode_next;
`else
  logic unused_inverse;
  assign unused_inverse = in_inverse;
`endif

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                           state_reg, state_next;
  logic [CNT_W-1:0]                 cnt_reg, cnt_next;
  logic [BEATS-1:0][LANES-1:0][7:0] word_reg, word_next;
  logic [LANES-1:0][7:0]            sub_out;
  logic                             init_reg;

  // Each lane substitutes one byte of the group selected by the beat counter.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_in;
      assign lane_in = word_reg[cnt_reg][gi];
`ifdef SBOX_LANE_FWD_EN
      assign sub_out[gi] = mode_reg ? inv_sbox(lane_in) : fwd_sbox(lane_in);
`else
      assign sub_out[gi] = inv_sbox(lane_in);
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      init_reg  <= 1'b0;
`ifdef SBOX_LANE_FWD_EN
      mode_reg  <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      init_reg  <= 1'b1;
`ifdef SBOX_LANE_FWD_EN
      mode_reg  <= mode_next;
`endif
    end
  end

  always_comb begin
    logic load;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
`ifdef SBOX_LANE_FWD_EN
    mode_next  = mode_reg;
`endif
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        // init_reg holds off acceptance until the first edge after reset release
        in_ready = init_reg;
        load     = in_valid && init_reg;
      end
      SUB: begin
        busy               = 1'b1;
        word_next[cnt_reg] = sub_out;
        if (cnt_reg == CNT_W'(BEATS - 1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      word_next  = in_word;
      cnt_next   = '0;
      state_next = SUB;
`ifdef SBOX_LANE_FWD_EN
      mode_next  = in_inverse;
`endif
    end
  end

  assign out_word = word_reg;

endmodule
